// File: rtl/line_writer_pkg.sv
// Shared types and sizing helpers for the line writer
// and the line FIFO consumer side.
package line_writer_pkg;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    H_BLANK = 2'd1,
    IN_LINE = 2'd2
  } lw_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Pointer width; a one-entry FIFO still needs one bit.
  function automatic int sel_width(input int bs);
    return (clog2(bs) < 1) ? 1 : clog2(bs);
  endfunction

endpackage

// File: rtl/line_writer_if.sv
// Line-RAM write bus.
// master: drives strobe, RAM select, address, data.
interface line_writer_if #(
  parameter int DW = 16,
  parameter int AW = 11,
  parameter int SW = 2
);
  logic          ramWrEn;
  logic [SW-1:0] ramWrSel;
  logic [AW-1:0] ramAddrIn;
  logic [DW-1:0] ramWrData;

  modport master (
    output ramWrEn, ramWrSel,
    output ramAddrIn, ramWrData
  );

  modport slave (
    input ramWrEn, ramWrSel,
    input ramAddrIn, ramWrData
  );
endinterface

// File: rtl/line_writer_fifo_ptr.sv
// Line FIFO bookkeeping: write/read pointers and count.
// Ports: commit (+1 line), rel1/rel2 (release 1/2 lines).
module line_fifo_ptr
  import line_writer_pkg::*;
#(
  parameter int BUFFER_SIZE = 4,
  localparam int SW = sel_width(BUFFER_SIZE),
  localparam int CW = SW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          commit,
  input  logic          rel1,
  input  logic          rel2,
  output logic [SW-1:0] wr_ptr,
  output logic [SW-1:0] rd_ptr,
  output logic [CW-1:0] count
);

  localparam logic [CW:0] BS_W =
    (CW+1)'(BUFFER_SIZE);

  logic [SW-1:0] wr_ptr_q, wr_ptr_d;
  logic [SW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] req, rel;
  logic [CW:0]   wr_sum, rd_sum;

  always_comb begin
    req = rel2 ? CW'(2) :
          rel1 ? CW'(1) : '0;
    // Release never takes more than is held.
    rel = (req > cnt_q) ? cnt_q : req;
    cnt_d = cnt_q + CW'(commit) - rel;
    wr_sum = (CW+1)'(wr_ptr_q) + (CW+1)'(commit);
    rd_sum = (CW+1)'(rd_ptr_q) + (CW+1)'(rel);
    wr_ptr_d = (wr_sum >= BS_W) ?
      SW'(wr_sum - BS_W) : SW'(wr_sum);
    rd_ptr_d = (rd_sum >= BS_W) ?
      SW'(rd_sum - BS_W) : SW'(rd_sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = cnt_q;

endmodule

// File: rtl/line_writer.sv
// Crops a video stream to a window and writes kept lines
// into a ring of line RAMs. In: HS/VS/dInEn/dIn, window,
// jmp1/jmp2. Out: ram bus, rdSel, fifoNum, overflow.
module line_writer
  import line_writer_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int ADDRESS_WIDTH   = 11,
  parameter int BUFFER_SIZE     = 4,
  parameter int INPUT_RES_WIDTH = 11,
  localparam int BUFFER_SIZE_WIDTH =
    sel_width(BUFFER_SIZE),
  localparam int COUNT_WIDTH = BUFFER_SIZE_WIDTH + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       HS,
  input  logic                       VS,
  input  logic                       dInEn,
  input  logic [DATA_WIDTH-1:0]      dIn,
  input  logic [INPUT_RES_WIDTH-1:0] xBgn,
  input  logic [INPUT_RES_WIDTH-1:0] xEnd,
  input  logic [INPUT_RES_WIDTH-1:0] yBgn,
  input  logic [INPUT_RES_WIDTH-1:0] yEnd,
  input  logic                       jmp1,
  input  logic                       jmp2,
  line_writer_if.master              ram,
  output logic [BUFFER_SIZE_WIDTH-1:0] rdSel,
  output logic [COUNT_WIDTH-1:0]     fifoNum,
  output logic                       overflow
);

  localparam int IRW = INPUT_RES_WIDTH;
  localparam int AW  = ADDRESS_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] FULL =
    COUNT_WIDTH'(BUFFER_SIZE);

  lw_state_e state_q, state_d;
  logic hs_q, vs_q;
  logic [IRW-1:0] x_q, x_d, y_q, y_d;
  logic seen_q, seen_d;
  logic blk_q, blk_d;
  logic kept_q, kept_d;
  logic we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic ovf_q, ovf_d;

  logic hs_edge, vs_edge, pix, in_win;
  logic blk_now, keep, commit;
  logic [IRW-1:0] x_off;
  logic [BUFFER_SIZE_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [COUNT_WIDTH-1:0] cnt;

  line_fifo_ptr #(
    .BUFFER_SIZE(BUFFER_SIZE)
  ) u_ptr (
    .clk   (clk),
    .rst   (rst),
    .commit(commit),
    .rel1  (jmp1),
    .rel2  (jmp2),
    .wr_ptr(wr_ptr),
    .rd_ptr(rd_ptr),
    .count (cnt)
  );

  always_comb begin
    hs_edge = HS & ~hs_q;
    vs_edge = VS & ~vs_q;
    in_win = (x_q >= xBgn) && (x_q <= xEnd) &&
             (y_q >= yBgn) && (y_q <= yEnd);
    pix = dInEn && (state_q != WAIT_VS) && !vs_edge;
    // Block decision is frozen at the first in-window
    // pixel so a line is never half written.
    blk_now = seen_q ? blk_q : (cnt == FULL);
    keep = pix && in_win && !blk_now;
    x_off = x_q - xBgn;

    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    seen_d  = seen_q;
    blk_d   = blk_q;
    kept_d  = kept_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    ovf_d   = 1'b0;
    commit  = 1'b0;

    if (vs_edge) begin
      state_d = H_BLANK;
      x_d     = '0;
      y_d     = '0;
      seen_d  = 1'b0;
      blk_d   = 1'b0;
      kept_d  = 1'b0;
    end else begin
      if (pix) begin
        x_d = x_q + IRW'(1);
        if (state_q == H_BLANK) state_d = IN_LINE;
        if (in_win && !seen_q) begin
          seen_d = 1'b1;
          blk_d  = blk_now;
        end
        if (keep) begin
          we_d   = 1'b1;
          addr_d = AW'(x_off);
          data_d = dIn;
          kept_d = 1'b1;
        end
      end
      if (hs_edge) begin
        commit = kept_q;
        ovf_d  = seen_q & blk_q;
        x_d    = '0;
        y_d    = (&y_q) ? y_q : y_q + IRW'(1);
        seen_d = 1'b0;
        blk_d  = 1'b0;
        kept_d = 1'b0;
        if (state_q == IN_LINE) state_d = H_BLANK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_VS;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      seen_q  <= 1'b0;
      blk_q   <= 1'b0;
      kept_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hs_q    <= HS;
      vs_q    <= VS;
      x_q     <= x_d;
      y_q     <= y_d;
      seen_q  <= seen_d;
      blk_q   <= blk_d;
      kept_q  <= kept_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ram.ramWrEn   = we_q;
  assign ram.ramWrSel  = wr_ptr;
  assign ram.ramAddrIn = addr_q;
  assign ram.ramWrData = data_q;
  assign rdSel    = rd_ptr;
  assign fifoNum  = cnt;
  assign overflow = ovf_q;

endmodule
